// File: rtl/alu_seq.sv
// Registered ALU with a single-cycle logic/arithmetic path and an iterative shift-add
// unsigned multiplier, behind a start/busy/done handshake. One operation in flight.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       signal,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic               sub_op;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               last_step;

  // Shared adder: SUB and SLT use a + ~b + 1, so carry-out is the no-borrow flag.
  always_comb begin
    sub_op  = signal[2] & signal[1];
    b_eff   = sub_op ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (signal)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SLT: begin
        alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        alu_c   = sum[WIDTH];
      end
      default: ;
    endcase
  end

  assign acc_step  = mplier[0] ? acc + mcand : acc;
  assign last_step = (state == MUL) && (cnt == CNT_W'(1));

  // FIN is the done cycle of a multiply; it accepts a new request just like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: state_nxt = (start && signal == OP_MUL) ? MUL : IDLE;
      MUL:       if (last_step) state_nxt = FIN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      hi     <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start && signal == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
          end else if (start) begin
            out   <= alu_res;
            hi    <= '0;
            zero  <= (alu_res == '0);
            carry <= alu_c;
            ovf   <= alu_v;
            done  <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          // Results are registered from the final step so done lands in the FIN cycle.
          if (last_step) begin
            out   <= acc_step[WIDTH-1:0];
            hi    <= acc_step[2*WIDTH-1:WIDTH];
            zero  <= (acc_step == '0);
            carry <= 1'b0;
            ovf   <= (acc_step[2*WIDTH-1:WIDTH] != '0);
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: an 8-bit and a 4-bit instance, directed vectors with
// hand-computed results queued at issue time and checked by per-instance monitors.
module tb_alu_seq;

  typedef struct packed {
    logic [63:0] tag;
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b010, MUL_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, NOR_ = 3'b101, SUB_ = 3'b110, SLT_ = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] cyc = 0;
  int passed = 0;
  int total  = 0;
  exp_t q8[$];
  exp_t q4[$];

  logic       start8, start4;
  logic [7:0] a8, b8, out8, hi8;
  logic [3:0] a4, b4, out4, hi4;
  logic [2:0] sig8, sig4;
  logic       zero8, carry8, ovf8, busy8, done8;
  logic       zero4, carry4, ovf4, busy4, done4;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .signal(sig8),
    .out(out8), .hi(hi8), .zero(zero8), .carry(carry8), .ovf(ovf8),
    .busy(busy8), .done(done8)
  );

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .signal(sig4),
    .out(out4), .hi(hi4), .zero(zero4), .carry(carry4), .ovf(ovf4),
    .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [63:0] tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", tag, act, req);
    else passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      total++;
      if (q8.size() == 0) $display("FAIL w8_unexpected_done actual=done required=no_done cyc=%0d", cyc);
      else begin
        e = q8.pop_front();
        if (32'(out8) !== e.out || 32'(hi8) !== e.hi || zero8 !== e.zero ||
            carry8 !== e.carry || ovf8 !== e.ovf || cyc !== e.cyc)
          $display("FAIL w8_%s actual=out:%0h hi:%0h z:%0b c:%0b v:%0b cyc:%0d required=out:%0h hi:%0h z:%0b c:%0b v:%0b cyc:%0d",
                   e.tag, out8, hi8, zero8, carry8, ovf8, cyc, e.out, e.hi, e.zero, e.carry, e.ovf, e.cyc);
        else passed++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4) begin
      total++;
      if (q4.size() == 0) $display("FAIL w4_unexpected_done actual=done required=no_done cyc=%0d", cyc);
      else begin
        e = q4.pop_front();
        if (32'(out4) !== e.out || 32'(hi4) !== e.hi || zero4 !== e.zero ||
            carry4 !== e.carry || ovf4 !== e.ovf || cyc !== e.cyc)
          $display("FAIL w4_%s actual=out:%0h hi:%0h z:%0b c:%0b v:%0b cyc:%0d required=out:%0h hi:%0h z:%0b c:%0b v:%0b cyc:%0d",
                   e.tag, out4, hi4, zero4, carry4, ovf4, cyc, e.out, e.hi, e.zero, e.carry, e.ovf, e.cyc);
        else passed++;
      end
    end
  end

  task automatic drive8(input logic [63:0] tag, input logic [2:0] op, input logic [7:0] ia, ib,
                        input logic [7:0] eo, eh, input logic ez, ec, ev, input bit push);
    exp_t e;
    start8 = 1'b1; sig8 = op; a8 = ia; b8 = ib;
    if (push) begin
      e.tag = tag; e.out = 32'(eo); e.hi = 32'(eh);
      e.zero = ez; e.carry = ec; e.ovf = ev;
      e.cyc = cyc + ((op == MUL_) ? 32'd9 : 32'd1);
      q8.push_back(e);
    end
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic drive4(input logic [63:0] tag, input logic [2:0] op, input logic [3:0] ia, ib,
                        input logic [3:0] eo, eh, input logic ez, ec, ev);
    exp_t e;
    start4 = 1'b1; sig4 = op; a4 = ia; b4 = ib;
    e.tag = tag; e.out = 32'(eo); e.hi = 32'(eh);
    e.zero = ez; e.carry = ec; e.ovf = ev;
    e.cyc = cyc + ((op == MUL_) ? 32'd5 : 32'd1);
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // Multiply on the 8-bit instance; a conflicting request is pulsed in busy cycle 3.
  task automatic mul8(input logic [63:0] tag, input logic [7:0] ia, ib,
                      input logic [7:0] eo, eh, input logic ez, ev);
    drive8(tag, MUL_, ia, ib, eo, eh, ez, 1'b0, ev, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      chk("busy8_on", 32'(busy8), 32'd1);
      if (k == 3) begin
        start8 = 1'b1; sig8 = ADD_; a8 = 8'h12; b8 = 8'h34;
      end else start8 = 1'b0;
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    chk("busy8_off", 32'(busy8), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; sig8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0; sig4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out8", {out8, hi8, 7'd0, zero8, carry8, ovf8, busy8, done8}, 32'd0);
    chk("rst_out4", {out4, hi4, 19'd0, zero4, carry4, ovf4, busy4, done4}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive8("ADD", ADD_, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    drive8("SUBEQ", SUB_, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    drive8("SLT", SLT_, 8'hFE, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    mul8("MULFF", 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1);
    drive8("AND", AND_, 8'hA5, 8'h0F, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive8("OR", OR_, 8'hA5, 8'h0F, 8'hAF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive8("XOR", XOR_, 8'hA5, 8'h0F, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive8("NOR", NOR_, 8'hA5, 8'h0F, 8'h50, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    mul8("MUL0", 8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0);
    drive8("ADDWRAP", ADD_, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    drive8("SUBNEG", SUB_, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive8("SUBOVF", SUB_, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    drive8("SLTNO", SLT_, 8'h01, 8'hFE, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold8", {out8, 7'd0, zero8}, {8'h00, 7'd0, 1'b1});

    drive4("SLT4", SLT_, 4'h7, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive4("MUL4", MUL_, 4'hF, 4'hF, 4'h1, 4'hE, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("busy4_on", 32'(busy4), 32'd1);
      @(posedge clk); #1;
    end
    chk("busy4_off", 32'(busy4), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    drive8("OR2", OR_, 8'hA5, 8'h0F, 8'hAF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive8("MULRST", MUL_, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_busy8", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_w8", {out8, hi8, 7'd0, zero8, carry8, ovf8, busy8, done8}, 32'd0);
    chk("rst_mid_w4", {out4, hi4, 19'd0, zero4, carry4, ovf4, busy4, done4}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    drive8("XORPOST", XOR_, 8'hA5, 8'h0F, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 50 && (q8.size() != 0 || q4.size() != 0); i++) @(posedge clk);
    #1;
    if (q8.size() != 0 || q4.size() != 0) begin
      total++;
      $display("FAIL drain actual=%0d_pending required=0_pending", q8.size() + q4.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
